// File: rtl/s820_bist_pkg.sv
// Shared types and defaults for the s820 BIST response path: FSM states,
// MISR geometry and the s820 output bit ordering inside the response vector.
package s820_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } misr_state_e;

  localparam int          MISR_SIG_W = 32;
  localparam int          MISR_CNT_W = 16;
  localparam logic [31:0] MISR_POLY  = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED  = 32'h00000000;

  // s820 outputs are concatenated G290 (msb) down to G302 (lsb)
  localparam int S820_RESP_W    = 19;
  localparam int S820_G290_BIT  = 18;
  localparam int S820_G302_BIT  = 0;

endpackage

// File: rtl/s820_resp_misr_core.sv
// MISR datapath: one shift/feedback/fold step per enabled cycle, plus the
// signature register with a synchronous seed load.
module misr_core #(
  parameter int                IN_W  = 19,
  parameter int                SIG_W = 32,
  parameter logic [SIG_W-1:0]  POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]  SEED  = 32'h00000000
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             load,
  input  logic             en,
  input  logic [IN_W-1:0]  resp_in,
  output logic [SIG_W-1:0] sig_next,
  output logic [SIG_W-1:0] signature
);

  logic [SIG_W-1:0] sig_reg;
  logic [SIG_W-1:0] din_ext;

  generate
    for (genvar gi = 0; gi < SIG_W; gi++) begin : g_bit
      if (gi < IN_W) begin : g_din
        assign din_ext[gi] = resp_in[gi];
      end else begin : g_pad
        assign din_ext[gi] = 1'b0;
      end

      // bit 0 receives no shifted-in bit, only feedback and data
      if (gi == 0) begin : g_lsb
        assign sig_next[gi] = (POLY[gi] & sig_reg[SIG_W-1]) ^ din_ext[gi];
      end else begin : g_upper
        assign sig_next[gi] = sig_reg[gi-1] ^ (POLY[gi] & sig_reg[SIG_W-1]) ^ din_ext[gi];
      end
    end
  endgenerate

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      sig_reg <= '0;
    end else if (load) begin
      sig_reg <= SEED;
    end else if (en) begin
      sig_reg <= sig_next;
    end
  end

  assign signature = sig_reg;

endmodule

// File: rtl/s820_resp_misr.sv
// s820 response compactor: counts num_samples accepted responses into a MISR.
// Optional golden compare enabled by S820_MISR_GOLDEN_CMP_EN.
module s820_resp_misr
  import s820_bist_pkg::*;
#(
  parameter int                IN_W  = S820_RESP_W,
  parameter int                SIG_W = MISR_SIG_W,
  parameter int                CNT_W = MISR_CNT_W,
  parameter logic [SIG_W-1:0]  POLY  = MISR_POLY,
  parameter logic [SIG_W-1:0]  SEED  = MISR_SEED
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [IN_W-1:0]  resp_in,
  input  logic             resp_valid,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature
`ifdef S820_MISR_GOLDEN_CMP_EN
  ,
  input  logic [SIG_W-1:0] golden,
  output logic             match,
  output logic             fail
`endif
);

  misr_state_e      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             load;
  logic             en;
  logic [SIG_W-1:0] sig_next;

  misr_core #(
    .IN_W  (IN_W),
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .blif_clk_net   (blif_clk_net),
    .blif_reset_net (blif_reset_net),
    .load           (load),
    .en             (en),
    .resp_in        (resp_in),
    .sig_next       (sig_next),
    .signature      (signature)
  );

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Exit is decided on cnt_reg==1 before decrementing, so the counter never wraps.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    en         = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          cnt_next   = num_samples;
          state_next = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (resp_valid) begin
          en       = 1'b1;
          cnt_next = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

`ifdef S820_MISR_GOLDEN_CMP_EN
  logic match_reg, fail_reg;

  // A zero-sample capture finishes on the start edge with the seed as its result.
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      match_reg <= 1'b0;
      fail_reg  <= 1'b0;
    end else if (load) begin
      match_reg <= (num_samples == '0) && (SEED == golden);
      fail_reg  <= (num_samples == '0) && (SEED != golden);
    end else if (state_reg == RUN && state_next == DONE) begin
      match_reg <= (sig_next == golden);
      fail_reg  <= (sig_next != golden);
    end
  end

  assign match = match_reg;
  assign fail  = fail_reg;
`else
  wire unused_sig_next = ^sig_next;
`endif

endmodule

// File: tb/tb_s820_resp_misr.sv
// Directed bench for s820_resp_misr with hand-computed signatures.
// Define S820_MISR_GOLDEN_CMP_EN to also exercise the golden compare.
module tb_s820_resp_misr;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_samples;
  logic [18:0] resp_in;
  logic        resp_valid;
  logic        busy;
  logic        done;
  logic [31:0] signature;
`ifdef S820_MISR_GOLDEN_CMP_EN
  logic [31:0] golden;
  logic        match;
  logic        fail;
`endif

  int errors = 0;
  int checks = 0;

  s820_resp_misr dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .start          (start),
    .num_samples    (num_samples),
    .resp_in        (resp_in),
    .resp_valid     (resp_valid),
    .busy           (busy),
    .done           (done),
    .signature      (signature)
`ifdef S820_MISR_GOLDEN_CMP_EN
    ,
    .golden         (golden),
    .match          (match),
    .fail           (fail)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Valid pattern 1,0,0,1,1 with a stray start during the second gap
  logic        gap_valid [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        gap_start [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [18:0] gap_data  [5] = '{19'h40000, 19'h7FFFF, 19'h7FFFF, 19'h12345, 19'h00F0F};
  logic [18:0] run_data  [3] = '{19'h40000, 19'h12345, 19'h00F0F};

  initial begin
    rst = 1'b1; start = 1'b0; num_samples = '0; resp_in = '0; resp_valid = 1'b0;
`ifdef S820_MISR_GOLDEN_CMP_EN
    golden = 32'h00000001;
`endif
    tick(); tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sig", signature, 32'h0);
    rst = 1'b0;

    // single sample of 1
    start = 1'b1; num_samples = 16'd1; resp_in = 19'h00001; resp_valid = 1'b1;
    tick();
    check("t1_busy_after_start", 32'(busy), 32'd1);
    check("t1_sig_seed", signature, 32'h0);
    start = 1'b0;
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_sig", signature, 32'h00000001);
`ifdef S820_MISR_GOLDEN_CMP_EN
    check("t1_match", 32'(match), 32'd1);
    check("t1_fail", 32'(fail), 32'd0);
`endif
    resp_valid = 1'b0;

    // single all-ones sample
    start = 1'b1; num_samples = 16'd1;
    tick();
    start = 1'b0; resp_in = 19'h7FFFF; resp_valid = 1'b1;
    tick();
    check("t2_sig", signature, 32'h0007FFFF);
    check("t2_done", 32'(done), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    resp_valid = 1'b0;

    // walk a one up to the msb, then wrap through the feedback
    start = 1'b1; num_samples = 16'd33;
    tick();
    start = 1'b0; resp_in = 19'h00001; resp_valid = 1'b1;
    tick();
    resp_in = 19'h0;
    repeat (31) tick();
    check("t3_sig32", signature, 32'h80000000);
    check("t3_busy32", 32'(busy), 32'd1);
    tick();
    check("t3_sig33", signature, 32'h04C11DB7);
    check("t3_done33", 32'(done), 32'd1);
    resp_valid = 1'b0;

    // gapped run with a stray start
    start = 1'b1; num_samples = 16'd3;
    tick();
    for (int i = 0; i < 5; i++) begin
      start = gap_start[i]; resp_valid = gap_valid[i]; resp_in = gap_data[i];
      tick();
      if (i == 3) begin
        check("t4_not_done_edge4", 32'(done), 32'd0);
        check("t4_busy_edge4", 32'(busy), 32'd1);
      end
    end
    start = 1'b0; resp_valid = 1'b0;
    check("t4_done_edge5", 32'(done), 32'd1);
    check("t4_sig_gapped", signature, 32'h00124985);

    // same data without gaps
    start = 1'b1; num_samples = 16'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      resp_valid = 1'b1; resp_in = run_data[i];
      tick();
    end
    resp_valid = 1'b0;
    check("t4_sig_gapfree", signature, 32'h00124985);
    check("t4_done_gapfree", 32'(done), 32'd1);

    // zero samples: straight to done with the seed
    start = 1'b1; num_samples = 16'd0; resp_valid = 1'b1; resp_in = 19'h55555;
    tick();
    check("t5_done", 32'(done), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_sig_seed", signature, 32'h0);
    start = 1'b0;
    tick();
    check("t5_sig_hold", signature, 32'h0);
    check("t5_done_hold", 32'(done), 32'd1);
    resp_valid = 1'b0;

    // asynchronous reset part-way through a capture
    start = 1'b1; num_samples = 16'd10;
    tick();
    start = 1'b0; resp_valid = 1'b1; resp_in = 19'h00001;
    repeat (5) tick();
    check("t6_sig_5", signature, 32'h0000001F);
    check("t6_busy_5", 32'(busy), 32'd1);
    resp_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_sig", signature, 32'h0);
    tick();
    rst = 1'b0;
    start = 1'b1; num_samples = 16'd1;
    tick();
    start = 1'b0; resp_in = 19'h7FFFF; resp_valid = 1'b1;
    tick();
    check("t6_rerun_sig", signature, 32'h0007FFFF);
    check("t6_rerun_done", 32'(done), 32'd1);
    resp_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s820_resp_misr.md
# s820_resp_misr

Downstream response compactor for the s820 sequential benchmark: it consumes the 19 primary outputs of the s820 core every clock and folds them into a 32-bit multiple-input signature register (MISR) over a programmable number of cycles. It sits directly after the s820 instance in the BIST wrapper, on the same clock mesh leaf. A single signature can then be read out and compared, which lets us check mesh-induced skew and variation effects on the core without probing 19 outputs every cycle.

## Interface
Parameters:
- IN_W, 19, response width (s820 outputs, concatenated G290 as bit 18 down to G302 as bit 0)
- SIG_W, 32, signature width; must be ≥ IN_W
- CNT_W, 16, sample-counter width
- POLY, 32'h04C11DB7, MISR feedback polynomial (x^32 term implicit)
- SEED, 32'h00000000, signature value loaded on start

Ports:
- blif_clk_net  in  1  clock, rising edge
- blif_reset_net  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request to begin a capture
- num_samples  in  CNT_W  samples to compact; sampled with start
- resp_in  in  IN_W  s820 response vector
- resp_valid  in  1  resp_in is a valid sample this cycle
- busy  out  1  capture in progress
- done  out  1  capture finished; signature is final
- signature  out  SIG_W  current MISR contents

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is 2 bits; reset state is IDLE.
- Reset values: state IDLE, busy 0, done 0, signature 0, counter 0.
- IDLE or DONE with start=1:
  - load signature←SEED and counter←num_samples;
  - go to RUN, or go straight to DONE if num_samples==0.
- RUN with resp_valid=1 (an accepted sample):
  - sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_ext(resp_in);
  - counter decrements;
  - if counter==1 before the decrement, go to DONE.
- RUN with resp_valid=0: signature and counter hold.
- start during RUN is ignored; the capture continues unaffected.
- DONE holds the signature stable until the next start.
- busy = (state==RUN). done = (state==DONE).
- Counter arithmetic is unsigned. It never underflows because the exit condition is checked before the decrement.
- Reset asserted mid-capture aborts it immediately to the reset values. No partial signature is retained.

## Timing
- start at edge N: busy=1 (or done=1 if num_samples==0) visible after edge N. signature==SEED after edge N.
- Each accepted sample updates signature at that same edge. Throughput is 1 sample/cycle.
- Final accepted sample at edge M: done=1 and busy=0 after edge M.
- Latency from start to done is num_samples + (number of idle cycles, i.e. resp_valid=0) clock edges.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- S820_MISR_GOLDEN_CMP_EN
  - Defined: adds input golden[SIG_W-1:0] and registered outputs match and fail.
    - On the edge entering DONE: match←(sig_next==golden), fail←~match.
    - Both hold through DONE. Both clear to 0 on start and on reset.
  - Undefined: those ports and registers are absent; behaviour is otherwise identical.

## Structure
- Package s820_bist_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default SIG_W, POLY, SEED and CNT_W constants;
  - the s820 response bit-ordering constants.
- Sub-module misr_core:
  - pure next-signature datapath plus the signature register, with enable and load/seed inputs;
  - the FSM and counter live in s820_resp_misr.

## Test plan
- Reset, then start with num_samples=1, resp_in=19'h00001, resp_valid=1 → done after 1 edge, signature=32'h00000001.
- num_samples=1, resp_in=19'h7FFFF → signature=32'h0007FFFF, done=1, busy=0.
- num_samples=33; feed 19'h00001 then 32 zeros → after 32 samples signature=32'h80000000; after the 33rd, 32'h04C11DB7 (feedback wrap).
- num_samples=3 with resp_valid toggling 1,0,0,1,1 → done asserted after the 5th edge. A second start pulsed mid-RUN → ignored, and the result equals the gap-free run.
- num_samples=0 → done=1 one edge after start, signature=SEED, busy never asserted.
- Reset asserted in RUN after 5 samples → all outputs 0 and state IDLE asynchronously. A new start gives a signature identical to a fresh run. With S820_MISR_GOLDEN_CMP_EN, golden=32'h00000001 on the first test → match=1, fail=0.
